cache_axi_bridge: RTL and testbench
===================================

Name: cache_axi_bridge

Overview:
Memory-side stage directly downstream of the cache. It converts the cache's refill/writeback request interface (rd_req/ret_* and wr_req/wr_*) into AXI4 read and write channel transactions toward the SoC interconnect. It has one outstanding read and one outstanding write, and strict write-before-read ordering, so uncached store→load sequences and writeback→refill sequences stay coherent.

Parameters:
AXI_ID, 4'd0, constant value driven on arid and awid.
LINE_WORDS, 4, 32-bit words per cache line; a line burst has arlen/awlen = LINE_WORDS-1.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
rd_req  in  1  cache read request
rd_type  in  3  000 byte, 001 half, 010 word, 100 line
rd_addr  in  32  read address
rd_rdy  out  1  read request accepted this cycle when rd_req=1
ret_valid  out  1  read return beat valid
ret_last  out  1  final return beat
ret_data  out  32  read return data
wr_req  in  1  cache write request
wr_type  in  3  same encoding as rd_type
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobes, single-beat writes only
wr_data  in  32*LINE_WORDS  line data; word k at bits [32k+31:32k]
wr_rdy  out  1  write request accepted this cycle when wr_req=1
arid/araddr/arlen/arsize/arburst  out  4/32/8/3/2  AXI AR payload
arvalid  out  1 ; arready  in  1
rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1 ; rready  out  1
awid/awaddr/awlen/awsize/awburst  out  4/32/8/3/2  AXI AW payload
awvalid  out  1 ; awready  in  1
wdata/wstrb/wlast/wvalid  out  32/4/1/1 ; wready  in  1
bid/bresp/bvalid  in  4/2/1 ; bready  out  1

Behaviour:
- Reset (resetn low, async): both FSMs idle; arvalid, rready, awvalid, wvalid, wlast, bready = 0; beat counter 0; latched payload regs 0. Reset mid-burst abandons the transaction with no recovery.
- Type mapping: 100 → len=LINE_WORDS-1, size=2, burst=INCR(01). 010/001/000 → len=0, size=2/1/0, burst=INCR. Address is passed unmodified.
- Ready: wr_rdy = (wfsm==W_IDLE). rd_rdy = (rfsm==R_IDLE) && (wfsm==W_IDLE) && !wr_req. When both requests arrive in the same cycle, the write wins. No read is accepted while a write is outstanding through its B response.
- Read FSM R_IDLE → R_AR → R_DATA → R_IDLE.
  - Accept (rd_req&&rd_rdy) latches addr and type; arvalid=1 from the next cycle.
  - arvalid is held, with a stable payload, until arready; then R_DATA.
  - In R_DATA: rready=1. ret_valid = rvalid, ret_data = rdata, ret_last = rlast, all combinational the same cycle. rresp and rid are ignored.
  - rvalid&&rlast returns to R_IDLE. ret_valid is 0 outside R_DATA.
- Write FSM W_IDLE → W_ADDR → W_RESP → W_IDLE.
  - Accept (wr_req&&wr_rdy) latches addr, type, wr_wstrb and the full wr_data. Next cycle: awvalid=1 and wvalid=1 together.
  - awvalid drops after its own awready handshake; the W channel proceeds independently.
  - W beat k (counter 0..len): line writes drive wdata = word k with wstrb=4'hf; single writes drive wdata = wr_data[31:0] with wstrb = latched strobe. wlast=1 when counter==len. The counter advances on wvalid&&wready.
  - When both the AW handshake and the last W handshake have completed (in any order, or the same cycle), go to W_RESP with bready=1. bvalid → W_IDLE. bresp is ignored.
- Payload outputs hold stable while their valid is high and wready/arready/awready is low. No combinational path from AXI ready inputs to cache-side ready outputs other than through FSM state.
- Throughput: min 1 idle cycle between back-to-back accepts on the same channel.

Test Plan:
- Line refill: rd_req, rd_type=100, rd_addr=0x1C000040 → araddr=0x1C000040, arlen=3, arsize=2, arburst=01. Four R beats 0xA0..0xA3 → four ret_valid beats with the same data; ret_last only on 0xA3; rd_rdy back to 1 the cycle after the last beat.
- Line writeback: wr_data={0xD3,0xD2,0xD1,0xD0}, wr_addr=0x00001230, wready toggling 1/0 → wdata sequence D0,D1,D2,D3, wstrb=f, wlast on D3 only, awlen=3. bvalid → wr_rdy returns to 1.
- Uncached store: wr_type=010, wr_wstrb=4'b0110, wr_data[31:0]=0x11223344 → single beat, awlen=0, wstrb=0110, wlast=1.
- Ordering: rd_req and wr_req asserted in the same cycle → wr_rdy=1, rd_rdy=0. arvalid stays 0 until the cycle after bvalid; read is issued afterward.
- Backpressure: arready held 0 for 5 cycles → arvalid and araddr stable throughout. AW handshake after the last W beat → still a single W_RESP entry.
- Async reset asserted mid read burst (after beat 1) → all valids/readies drop immediately; after release rd_rdy=wr_rdy=1 and the next request issues normally.

Source files
------------

// File: rtl/cache_axi_bridge.sv
// Converts cache refill/writeback requests into AXI4 read and write bursts.
// One read and one write in flight at a time; a pending write blocks new reads until its B response.
module cache_axi_bridge #(
    parameter logic [3:0] AXI_ID     = 4'd0,
    parameter int         LINE_WORDS = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    rd_req,
    input  logic [2:0]              rd_type,
    input  logic [31:0]             rd_addr,
    output logic                    rd_rdy,
    output logic                    ret_valid,
    output logic                    ret_last,
    output logic [31:0]             ret_data,
    input  logic                    wr_req,
    input  logic [2:0]              wr_type,
    input  logic [31:0]             wr_addr,
    input  logic [3:0]              wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic                    wr_rdy,
    output logic [3:0]              arid,
    output logic [31:0]             araddr,
    output logic [7:0]              arlen,
    output logic [2:0]              arsize,
    output logic [1:0]              arburst,
    output logic                    arvalid,
    input  logic                    arready,
    input  logic [3:0]              rid,
    input  logic [31:0]             rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    output logic                    rready,
    output logic [3:0]              awid,
    output logic [31:0]             awaddr,
    output logic [7:0]              awlen,
    output logic [2:0]              awsize,
    output logic [1:0]              awburst,
    output logic                    awvalid,
    input  logic                    awready,
    output logic [31:0]             wdata,
    output logic [3:0]              wstrb,
    output logic                    wlast,
    output logic                    wvalid,
    input  logic                    wready,
    input  logic [3:0]              bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    output logic                    bready
);
    localparam int         IW       = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

    typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rstate_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wstate_t;

    rstate_t     rstate_q, rstate_d;
    wstate_t     wstate_q, wstate_d;
    logic        arvalid_q, arvalid_d, rready_q, rready_d;
    logic [31:0] rd_addr_q, rd_addr_d;
    logic [2:0]  rd_type_q, rd_type_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
    logic        aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic [7:0]  beat_q, beat_d;
    logic [31:0] wr_addr_q, wr_addr_d;
    logic [2:0]  wr_type_q, wr_type_d;
    logic [3:0]  wr_strb_q, wr_strb_d;
    logic [31:0] wr_words_q [LINE_WORDS];
    logic [31:0] wr_words_d [LINE_WORDS];
    logic        wr_accept, rd_accept, aw_hs, w_hs, w_last_hs;
    logic [7:0]  wlen;
    logic        unused_inputs;

    function automatic logic [7:0] type_len(input logic [2:0] t);
        return (t == 3'b100) ? LINE_LEN : 8'd0;
    endfunction

    function automatic logic [2:0] type_size(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            3'b000:  s = 3'd0;
            3'b001:  s = 3'd1;
            default: s = 3'd2;
        endcase
        return s;
    endfunction

    // Write takes priority: a read is only accepted when no write is pending or arriving.
    assign wr_rdy    = (wstate_q == W_IDLE);
    assign rd_rdy    = (rstate_q == R_IDLE) && (wstate_q == W_IDLE) && !wr_req;
    assign wr_accept = wr_req && wr_rdy;
    assign rd_accept = rd_req && rd_rdy;

    assign wlen      = type_len(wr_type_q);
    assign aw_hs     = awvalid_q && awready;
    assign w_hs      = wvalid_q && wready;
    assign w_last_hs = w_hs && (beat_q == wlen);

    always_comb begin
        rstate_d  = rstate_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        rd_addr_d = rd_addr_q;
        rd_type_d = rd_type_q;
        case (rstate_q)
            R_IDLE: if (rd_accept) begin
                rd_addr_d = rd_addr;
                rd_type_d = rd_type;
                arvalid_d = 1'b1;
                rstate_d  = R_AR;
            end
            R_AR: if (arready) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                rstate_d  = R_DATA;
            end
            R_DATA: if (rvalid && rlast) begin
                rready_d = 1'b0;
                rstate_d = R_IDLE;
            end
            default: rstate_d = R_IDLE;
        endcase
    end

    always_comb begin
        wstate_d  = wstate_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        beat_d    = beat_q;
        wr_addr_d = wr_addr_q;
        wr_type_d = wr_type_q;
        wr_strb_d = wr_strb_q;
        case (wstate_q)
            W_IDLE: if (wr_accept) begin
                wr_addr_d = wr_addr;
                wr_type_d = wr_type;
                wr_strb_d = wr_wstrb;
                awvalid_d = 1'b1;
                wvalid_d  = 1'b1;
                beat_d    = 8'd0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                wstate_d  = W_ADDR;
            end
            W_ADDR: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_last_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end else if (w_hs) begin
                    beat_d = beat_q + 8'd1;
                end
                // AW and the final W beat may complete in either order or together.
                if ((aw_done_q || aw_hs) && (w_done_q || w_last_hs)) begin
                    bready_d = 1'b1;
                    wstate_d = W_RESP;
                end
            end
            W_RESP: if (bvalid) begin
                bready_d  = 1'b0;
                beat_d    = 8'd0;
                aw_done_d = 1'b0;
                w_done_d  = 1'b0;
                wstate_d  = W_IDLE;
            end
            default: wstate_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rstate_q  <= R_IDLE;
            wstate_q  <= W_IDLE;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            rd_addr_q <= '0;
            rd_type_q <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            beat_q    <= '0;
            wr_addr_q <= '0;
            wr_type_q <= '0;
            wr_strb_q <= '0;
        end else begin
            rstate_q  <= rstate_d;
            wstate_q  <= wstate_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            rd_addr_q <= rd_addr_d;
            rd_type_q <= rd_type_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            beat_q    <= beat_d;
            wr_addr_q <= wr_addr_d;
            wr_type_q <= wr_type_d;
            wr_strb_q <= wr_strb_d;
        end
    end

    for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line_word
        assign wr_words_d[gi] = wr_accept ? wr_data[32*gi +: 32] : wr_words_q[gi];
        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) wr_words_q[gi] <= '0;
            else         wr_words_q[gi] <= wr_words_d[gi];
        end
    end

    assign arid      = AXI_ID;
    assign araddr    = rd_addr_q;
    assign arlen     = type_len(rd_type_q);
    assign arsize    = type_size(rd_type_q);
    assign arburst   = 2'b01;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign ret_valid = rready_q && rvalid;
    assign ret_last  = rready_q && rlast;
    assign ret_data  = rdata;

    assign awid      = AXI_ID;
    assign awaddr    = wr_addr_q;
    assign awlen     = wlen;
    assign awsize    = type_size(wr_type_q);
    assign awburst   = 2'b01;
    assign awvalid   = awvalid_q;
    // Single-beat writes keep beat_q at 0, so word 0 carries their data.
    assign wdata     = wr_words_q[beat_q[IW-1:0]];
    assign wstrb     = (wr_type_q == 3'b100) ? 4'hf : wr_strb_q;
    assign wlast     = wvalid_q && (beat_q == wlen);
    assign wvalid    = wvalid_q;
    assign bready    = bready_q;

    assign unused_inputs = ^{rid, rresp, bid, bresp};
endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: reactive AXI slaves plus queue-based scoreboard monitors.
`timescale 1ns/1ps
module tb_cache_axi_bridge;
    logic         clk = 1'b0;
    logic         resetn;
    logic         rd_req, rd_rdy, ret_valid, ret_last;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr, ret_data;
    logic         wr_req, wr_rdy;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic [3:0]   arid, rid, awid, bid;
    logic [31:0]  araddr, rdata, awaddr, wdata;
    logic [7:0]   arlen, awlen;
    logic [2:0]   arsize, awsize;
    logic [1:0]   arburst, rresp, awburst, bresp;
    logic         arvalid, arready, rlast, rvalid, rready;
    logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [3:0]   wstrb;

    always #5 clk = ~clk;

    cache_axi_bridge #(.AXI_ID(4'd0), .LINE_WORDS(4)) dut (
        .clk(clk), .resetn(resetn),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {logic [31:0] addr; logic [7:0] len; logic [2:0] size; logic [1:0] burst;} ax_t;
    typedef struct packed {logic [31:0] data; logic [3:0] strb; logic last;} w_t;
    typedef struct packed {logic [31:0] data; logic last;} ret_t;

    ax_t  exp_ar[$], exp_aw[$];
    w_t   exp_w[$];
    ret_t exp_ret[$], r_beats[$];

    int n_checks = 0, n_fail = 0;
    int ar_delay = 0, aw_delay = 0, b_delay = 1;
    bit w_toggle = 1'b0;
    int b_entries = 0, aw_total = 0, wlast_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no event, expected one within the cycle budget", name);
    endtask

    // ---------------- AXI slave models ----------------
    initial begin : ar_slave
        int cnt; bit hs;
        cnt = 0; arready = 1'b0;
        forever begin
            @(negedge clk); hs = arvalid && arready;
            @(posedge clk); #1;
            if (!resetn || hs) begin arready = 1'b0; cnt = 0; end
            else if (arvalid && !arready) begin
                if (cnt >= ar_delay) arready = 1'b1; else cnt++;
            end
        end
    end

    initial begin : aw_slave
        int cnt; bit hs;
        cnt = 0; awready = 1'b0;
        forever begin
            @(negedge clk); hs = awvalid && awready;
            @(posedge clk); #1;
            if (!resetn || hs) begin awready = 1'b0; cnt = 0; end
            else if (awvalid && !awready) begin
                if (cnt >= aw_delay) awready = 1'b1; else cnt++;
            end
        end
    end

    initial begin : w_slave
        wready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (!resetn)       wready = 1'b0;
            else if (w_toggle) wready = !wready;
            else               wready = 1'b1;
        end
    end

    initial begin : r_slave
        bit hs; ret_t b;
        rvalid = 1'b0; rlast = 1'b0; rdata = '0; rid = '0; rresp = '0;
        forever begin
            @(negedge clk); hs = rvalid && rready;
            @(posedge clk); #1;
            if (!resetn) begin
                rvalid = 1'b0; rlast = 1'b0; r_beats.delete();
            end else if (hs || !rvalid) begin
                if (rready && r_beats.size() > 0) begin
                    b = r_beats.pop_front();
                    rvalid = 1'b1; rdata = b.data; rlast = b.last;
                end else begin
                    rvalid = 1'b0; rlast = 1'b0;
                end
            end
        end
    end

    initial begin : b_slave
        int cnt; bit hs;
        cnt = 0; bvalid = 1'b0; bid = '0; bresp = '0;
        forever begin
            @(negedge clk); hs = bvalid && bready;
            @(posedge clk); #1;
            if (!resetn || hs) begin bvalid = 1'b0; cnt = 0; end
            else if (bready && !bvalid) begin
                if (cnt >= b_delay) bvalid = 1'b1; else cnt++;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    ax_t         e_ax;
    w_t          e_w;
    ret_t        e_r;
    bit          ar_wait_prev = 1'b0, w_wait_prev = 1'b0, bready_prev = 1'b0;
    logic [44:0] ar_prev;
    logic [36:0] w_prev;

    always @(negedge clk) begin
        if (!resetn) begin
            ar_wait_prev = 1'b0; w_wait_prev = 1'b0; bready_prev = 1'b0;
        end else begin
            if (ar_wait_prev)
                chk("ar_stable", 64'({arvalid, araddr, arlen, arsize, arburst}), 64'({1'b1, ar_prev}));
            if (w_wait_prev)
                chk("w_stable", 64'({wvalid, wdata, wstrb, wlast}), 64'({1'b1, w_prev}));
            ar_wait_prev = arvalid && !arready;
            ar_prev      = {araddr, arlen, arsize, arburst};
            w_wait_prev  = wvalid && !wready;
            w_prev       = {wdata, wstrb, wlast};

            if (arvalid && arready) begin
                $display("AR  addr=%h len=%0d size=%0d burst=%0d", araddr, arlen, arsize, arburst);
                if (exp_ar.size() == 0) fail_now("ar_expected");
                else begin
                    e_ax = exp_ar.pop_front();
                    chk("ar_payload", 64'({araddr, arlen, arsize, arburst}), 64'(e_ax));
                    chk("arid", 64'(arid), 64'd0);
                end
            end
            if (awvalid && awready) begin
                $display("AW  addr=%h len=%0d size=%0d burst=%0d", awaddr, awlen, awsize, awburst);
                aw_total++;
                if (exp_aw.size() == 0) fail_now("aw_expected");
                else begin
                    e_ax = exp_aw.pop_front();
                    chk("aw_payload", 64'({awaddr, awlen, awsize, awburst}), 64'(e_ax));
                    chk("awid", 64'(awid), 64'd0);
                end
            end
            if (wvalid && wready) begin
                $display("W   data=%h strb=%h last=%0d", wdata, wstrb, wlast);
                if (wlast) wlast_total++;
                if (exp_w.size() == 0) fail_now("w_expected");
                else begin
                    e_w = exp_w.pop_front();
                    chk("w_beat", 64'({wdata, wstrb, wlast}), 64'(e_w));
                end
            end
            if (ret_valid) begin
                $display("RET data=%h last=%0d", ret_data, ret_last);
                if (exp_ret.size() == 0) fail_now("ret_expected");
                else begin
                    e_r = exp_ret.pop_front();
                    chk("ret_beat", 64'({ret_data, ret_last}), 64'(e_r));
                end
            end
            if (bready && !bready_prev) begin
                b_entries++;
                $display("B   response phase entered (write %0d)", b_entries);
                chk("wresp_after_aw", 64'(aw_total), 64'(b_entries));
                chk("wresp_after_wlast", 64'(wlast_total), 64'(b_entries));
            end
            bready_prev = bready;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic rd_wait_accept();
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); got = rd_rdy;
        end
        if (!got) fail_now("rd_accept_timeout");
        @(posedge clk); #1; rd_req = 1'b0;
    endtask

    task automatic do_read(input logic [2:0] t, input logic [31:0] a);
        @(posedge clk); #1;
        rd_type = t; rd_addr = a; rd_req = 1'b1;
        rd_wait_accept();
    endtask

    task automatic do_write(input logic [2:0] t, input logic [31:0] a, input logic [3:0] s,
                            input logic [127:0] d);
        bit got = 1'b0;
        @(posedge clk); #1;
        wr_type = t; wr_addr = a; wr_wstrb = s; wr_data = d; wr_req = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); got = wr_rdy;
        end
        if (!got) fail_now("wr_accept_timeout");
        @(posedge clk); #1; wr_req = 1'b0;
    endtask

    task automatic wait_ret_last();
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); got = ret_valid && ret_last;
        end
        if (!got) fail_now("ret_last_timeout");
    endtask

    task automatic wait_bresp(input bit check_ar);
        bit got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk);
            if (check_ar) chk("ar_held_during_write", 64'(arvalid), 64'd0);
            got = bvalid && bready;
        end
        if (!got) fail_now("bresp_timeout");
        else chk("wr_rdy_during_b", 64'(wr_rdy), 64'd0);
    endtask

    task automatic push_read(input ax_t ar, input logic [31:0] base, input int beats);
        exp_ar.push_back(ar);
        for (int k = 0; k < beats; k++) begin
            r_beats.push_back('{32'(base + 32'(k)), (k == beats - 1)});
            exp_ret.push_back('{32'(base + 32'(k)), (k == beats - 1)});
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin : stim
        bit got;
        rd_req = 1'b0; rd_type = '0; rd_addr = '0;
        wr_req = 1'b0; wr_type = '0; wr_addr = '0; wr_wstrb = '0; wr_data = '0;
        resetn = 1'b1;
        #1 resetn = 1'b0;
        #3;
        chk("reset_ctrl", 64'({arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid, rd_rdy, wr_rdy}),
            64'(9'b000000011));
        chk("reset_payload", 64'({araddr, awaddr}), 64'd0);
        #18 resetn = 1'b1;

        // Line refill
        push_read('{32'h1C000040, 8'd3, 3'd2, 2'b01}, 32'hA0, 4);
        do_read(3'b100, 32'h1C000040);
        wait_ret_last();
        chk("rd_rdy_on_last_beat", 64'(rd_rdy), 64'd0);
        @(negedge clk);
        chk("rd_rdy_after_last", 64'(rd_rdy), 64'd1);

        // Line writeback with toggling wready
        w_toggle = 1'b1;
        exp_aw.push_back('{32'h00001230, 8'd3, 3'd2, 2'b01});
        exp_w.push_back('{32'hD0, 4'hf, 1'b0});
        exp_w.push_back('{32'hD1, 4'hf, 1'b0});
        exp_w.push_back('{32'hD2, 4'hf, 1'b0});
        exp_w.push_back('{32'hD3, 4'hf, 1'b1});
        do_write(3'b100, 32'h00001230, 4'h0, {32'hD3, 32'hD2, 32'hD1, 32'hD0});
        wait_bresp(1'b0);
        @(negedge clk);
        chk("wr_rdy_after_b", 64'(wr_rdy), 64'd1);
        w_toggle = 1'b0;

        // Uncached word store with partial strobe
        exp_aw.push_back('{32'h00002000, 8'd0, 3'd2, 2'b01});
        exp_w.push_back('{32'h11223344, 4'b0110, 1'b1});
        do_write(3'b010, 32'h00002000, 4'b0110, {{3{32'hDEADBEEF}}, 32'h11223344});
        wait_bresp(1'b0);

        // Simultaneous requests: write first, read held off until B completes
        exp_aw.push_back('{32'h00002002, 8'd0, 3'd1, 2'b01});
        exp_w.push_back('{32'h55667788, 4'b1100, 1'b1});
        push_read('{32'h00003003, 8'd0, 3'd0, 2'b01}, 32'hEE, 1);
        @(posedge clk); #1;
        rd_req = 1'b1; rd_type = 3'b000; rd_addr = 32'h00003003;
        wr_req = 1'b1; wr_type = 3'b001; wr_addr = 32'h00002002; wr_wstrb = 4'b1100;
        wr_data = {{3{32'hDEADBEEF}}, 32'h55667788};
        @(negedge clk);
        chk("both_req_wr_rdy", 64'(wr_rdy), 64'd1);
        chk("both_req_rd_rdy", 64'(rd_rdy), 64'd0);
        @(posedge clk); #1; wr_req = 1'b0;
        wait_bresp(1'b1);
        rd_wait_accept();
        wait_ret_last();

        // AR backpressure: arready withheld for 5 cycles
        ar_delay = 5;
        push_read('{32'h40000010, 8'd0, 3'd2, 2'b01}, 32'h12345678, 1);
        do_read(3'b010, 32'h40000010);
        wait_ret_last();
        ar_delay = 0;

        // AW handshake after the only W beat
        aw_delay = 6;
        exp_aw.push_back('{32'h00005000, 8'd0, 3'd2, 2'b01});
        exp_w.push_back('{32'hCAFEF00D, 4'hf, 1'b1});
        do_write(3'b010, 32'h00005000, 4'hf, {{3{32'h0}}, 32'hCAFEF00D});
        wait_bresp(1'b0);
        aw_delay = 0;

        // Async reset in the middle of a line refill
        push_read('{32'h60000000, 8'd3, 3'd2, 2'b01}, 32'hB0, 4);
        do_read(3'b100, 32'h60000000);
        got = 1'b0;
        for (int k = 0; k < 200 && !got; k++) begin
            @(negedge clk); got = ret_valid && (ret_data == 32'hB2);
        end
        if (!got) fail_now("mid_burst_timeout");
        #2 resetn = 1'b0;
        #1;
        chk("reset_mid_burst", 64'({arvalid, rready, awvalid, wvalid, wlast, bready, ret_valid}), 64'd0);
        exp_ret.delete();
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", 64'({rd_rdy, wr_rdy}), 64'(2'b11));
        push_read('{32'h70000004, 8'd0, 3'd2, 2'b01}, 32'h0BADF00D, 1);
        do_read(3'b010, 32'h70000004);
        wait_ret_last();

        repeat (3) @(negedge clk);
        chk("queues_drained", 64'(exp_ar.size() + exp_aw.size() + exp_w.size() + exp_ret.size()), 64'd0);
        chk("wresp_entries", 64'(b_entries), 64'd4);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
